// File: rtl/base2_range_reduce_lanes.sv
// Per-lane FP16 t -> k = clamped floor(t), f = t - k rounded to FP16 (RNE), in a 2-stage valid/ready pipeline.
// Define BASE2_RR_FLAGS_EN to add the per-lane sat_o / nan_o flag ports and their registers.
module base2_range_reduce_lanes #(
  parameter int LANES = 4,
  parameter int K_W   = 8,
  parameter int K_MIN = -16,
  parameter int K_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [16*LANES-1:0]  t_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [K_W*LANES-1:0] k_o,
  output logic [16*LANES-1:0]  k_fp16_o,
  output logic [16*LANES-1:0]  f_o
`ifdef BASE2_RR_FLAGS_EN
  ,
  output logic [LANES-1:0]     sat_o,
  output logic [LANES-1:0]     nan_o
`endif
);

  localparam logic signed [17:0] KMIN_S = 18'(K_MIN);
  localparam logic signed [17:0] KMAX_S = 18'(K_MAX);
  localparam logic [15:0] F_BELOW_ONE = 16'h3BFF;
  localparam logic [15:0] F_NAN       = 16'h7E00;

  logic en;
  logic valid1_q, valid1_d, valid2_q, valid2_d;

  assign en      = !valid2_q || ready_i;
  assign ready_o = en;
  assign valid_o = valid2_q;

  always_comb begin
    valid1_d = en ? valid_i  : valid1_q;
    valid2_d = en ? valid1_q : valid2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [15:0]        t;
      logic [39:0]        mag;
      logic [23:0]        frac;
      logic signed [17:0] ipart_s, kpre;
      logic               hi, lo;
      logic signed [17:0] k1_d, k1_q;
      logic [23:0]        v1_d, v1_q;
      logic               spec1_d, spec1_q;
      logic [15:0]        fspec1_d, fspec1_q;
      logic               sat1_d, nan1_d;

      assign t = t_i[16*gi +: 16];

      // |t| as fixed point with 24 fraction bits; subnormals are m * 2^-24.
      always_comb begin
        mag = (t[14:10] == 5'd0) ? {30'd0, t[9:0]}
                                 : ({29'd0, 1'b1, t[9:0]} << (t[14:10] - 5'd1));
        frac    = mag[23:0];
        ipart_s = {2'b00, mag[39:24]};
        kpre    = t[15] ? (18'sd0 - ipart_s - ((frac != 24'd0) ? 18'sd1 : 18'sd0)) : ipart_s;
        k1_d     = kpre;
        v1_d     = t[15] ? (24'd0 - frac) : frac;
        spec1_d  = 1'b0;
        fspec1_d = 16'h0000;
        sat1_d   = 1'b0;
        nan1_d   = 1'b0;
        hi       = 1'b0;
        lo       = 1'b0;
        if (t[14:10] == 5'h1f) begin
          if (t[9:0] != 10'd0) begin
            k1_d     = KMAX_S;
            spec1_d  = 1'b1;
            fspec1_d = F_NAN;
            sat1_d   = 1'b1;
            nan1_d   = 1'b1;
          end else if (t[15]) begin
            lo = 1'b1;
          end else begin
            hi = 1'b1;
          end
        end else if (kpre > KMAX_S) begin
          hi = 1'b1;
        end else if (kpre < KMIN_S) begin
          lo = 1'b1;
        end
        if (hi) begin
          k1_d     = KMAX_S;
          spec1_d  = 1'b1;
          fspec1_d = F_BELOW_ONE;
          sat1_d   = 1'b1;
        end
        if (lo) begin
          k1_d     = KMIN_S;
          spec1_d  = 1'b1;
          fspec1_d = 16'h0000;
          sat1_d   = 1'b1;
        end
      end

      logic [4:0]         p;
      logic [23:0]        vn;
      logic [4:0]         ex;
      logic               rnd;
      logic [10:0]        mant_r;
      logic signed [17:0] k2;
      logic               reclamp;
      logic [17:0]        kmag;
      logic [3:0]         q;
      logic [11:0]        a_sh;
      logic [K_W-1:0]     k_d, k_q;
      logic [15:0]        kf_d, kf_q, f_d, f_q;

      // Values below 2^-14 are already FP16 subnormals in 2^-24 units and need no rounding.
      always_comb begin
        p = 5'd0;
        for (int i = 0; i < 24; i++) begin
          if (v1_q[i]) p = 5'(i);
        end
        vn      = v1_q << (5'd23 - p);
        ex      = p - 5'd9;
        rnd     = vn[12] && (vn[13] || (vn[11:0] != 12'd0));
        mant_r  = {1'b0, vn[22:13]} + {10'd0, rnd};
        k2      = k1_q;
        reclamp = 1'b0;
        if (spec1_q) begin
          f_d = fspec1_q;
        end else if (p < 5'd10) begin
          f_d = {6'd0, v1_q[9:0]};
        end else if (!mant_r[10]) begin
          f_d = {1'b0, ex, mant_r[9:0]};
        end else if (ex != 5'd14) begin
          f_d = {1'b0, ex + 5'd1, 10'd0};
        end else begin
          f_d = 16'h0000;
          k2  = k1_q + 18'sd1;
        end
        if (k2 > KMAX_S) begin
          k2      = KMAX_S;
          f_d     = F_BELOW_ONE;
          reclamp = 1'b1;
        end
        kmag = k2[17] ? (18'd0 - k2) : k2;
        q = 4'd0;
        for (int i = 0; i < 12; i++) begin
          if (kmag[i]) q = 4'(i);
        end
        a_sh = kmag[11:0] << (4'd11 - q);
        kf_d = (kmag[11:0] == 12'd0) ? 16'h0000 : {k2[17], 5'(q) + 5'd15, a_sh[10:1]};
        k_d  = k2[K_W-1:0];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          k1_q     <= '0;
          v1_q     <= '0;
          spec1_q  <= 1'b0;
          fspec1_q <= '0;
          k_q      <= '0;
          kf_q     <= '0;
          f_q      <= '0;
        end else if (en) begin
          k1_q     <= k1_d;
          v1_q     <= v1_d;
          spec1_q  <= spec1_d;
          fspec1_q <= fspec1_d;
          k_q      <= k_d;
          kf_q     <= kf_d;
          f_q      <= f_d;
        end
      end

      assign k_o[K_W*gi +: K_W]   = k_q;
      assign k_fp16_o[16*gi +: 16] = kf_q;
      assign f_o[16*gi +: 16]      = f_q;

      logic lane_unused;
      assign lane_unused = ^{vn[23], kmag[17:12], a_sh[11], a_sh[0]};

`ifdef BASE2_RR_FLAGS_EN
      logic sat1_q, nan1_q, sat2_q, nan2_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sat1_q <= 1'b0;
          nan1_q <= 1'b0;
          sat2_q <= 1'b0;
          nan2_q <= 1'b0;
        end else if (en) begin
          sat1_q <= sat1_d;
          nan1_q <= nan1_d;
          sat2_q <= sat1_q | reclamp;
          nan2_q <= nan1_q;
        end
      end
      assign sat_o[gi] = sat2_q;
      assign nan_o[gi] = nan2_q;
`else
      logic flags_unused;
      assign flags_unused = sat1_d ^ nan1_d ^ reclamp;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_base2_range_reduce_lanes.sv
// Scoreboard bench for base2_range_reduce_lanes: a real-arithmetic reference model predicts each beat,
// a negedge monitor pops and compares whenever a beat leaves the DUT, and checks stall stability.
module tb_base2_range_reduce_lanes;
  localparam int LANES = 4;
  localparam int K_W   = 8;
  localparam int K_MIN = -16;
  localparam int K_MAX = 16;

  logic                 clk, rst, valid_i, ready_o, valid_o, ready_i;
  logic [16*LANES-1:0]  t_i, k_fp16_o, f_o;
  logic [K_W*LANES-1:0] k_o;
`ifdef BASE2_RR_FLAGS_EN
  logic [LANES-1:0]     sat_o, nan_o;
`endif

  base2_range_reduce_lanes #(.LANES(LANES), .K_W(K_W), .K_MIN(K_MIN), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .t_i(t_i),
    .valid_o(valid_o), .ready_i(ready_i), .k_o(k_o), .k_fp16_o(k_fp16_o), .f_o(f_o)
`ifdef BASE2_RR_FLAGS_EN
    , .sat_o(sat_o), .nan_o(nan_o)
`endif
  );

  typedef struct packed {
    logic signed [31:0] k;
    logic [15:0] kf;
    logic [15:0] f;
    logic sat;
    logic nan;
  } lane_t;

  typedef struct {
    logic [K_W*LANES-1:0] k;
    logic [16*LANES-1:0]  kf;
    logic [16*LANES-1:0]  f;
    logic [LANES-1:0]     sat;
    logic [LANES-1:0]     nan;
    int                   acc;
    bit                   lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;

  logic [15:0] dt  [3][4] = '{'{16'h4100, 16'hC100, 16'hB400, 16'h8000},
                              '{16'h8001, 16'h0001, 16'hBC00, 16'hB801},
                              '{16'h5640, 16'hD640, 16'h7C00, 16'h7E00}};
  int          dk  [3][4] = '{'{2, -3, -1, 0}, '{0, 0, -1, -1}, '{16, -16, 16, 16}};
  logic [15:0] dkf [3][4] = '{'{16'h4000, 16'hC200, 16'hBC00, 16'h0000},
                              '{16'h0000, 16'h0000, 16'hBC00, 16'hBC00},
                              '{16'h4C00, 16'hCC00, 16'h4C00, 16'h4C00}};
  logic [15:0] df  [3][4] = '{'{16'h3800, 16'h3800, 16'h3A00, 16'h0000},
                              '{16'h0000, 16'h0001, 16'h0000, 16'h37FE},
                              '{16'h3BFF, 16'h0000, 16'h3BFF, 16'h7E00}};
  logic [3:0]  dsat [3] = '{4'b0000, 4'b0000, 4'b1111};
  logic [3:0]  dnan [3] = '{4'b0000, 4'b0000, 4'b1000};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic real pow2(int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_to_real(logic [15:0] h);
    real v;
    int e = int'(h[14:10]);
    int m = int'(h[9:0]);
    if (e == 0) v = real'(m) * pow2(-24);
    else        v = real'(1024 + m) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // Round-to-nearest-even encoding of a finite real into FP16.
  function automatic logic [15:0] real_to_fp16(real x);
    logic sgn = (x < 0.0);
    real  a   = sgn ? -x : x;
    real  sc, fl, rem;
    int   ex, mi;
    if (a == 0.0) return 16'h0000;
    if (a < pow2(-14)) begin
      sc = a * pow2(24);
      fl = $floor(sc);
      rem = sc - fl;
      mi = int'(fl);
      if (rem > 0.5 || (rem == 0.5 && (mi % 2) == 1)) mi++;
      return {sgn, 15'(mi)};
    end
    ex = 0;
    while (a >= pow2(ex + 1)) ex++;
    while (a < pow2(ex)) ex--;
    sc = a * pow2(10 - ex);
    fl = $floor(sc);
    rem = sc - fl;
    mi = int'(fl);
    if (rem > 0.5 || (rem == 0.5 && (mi % 2) == 1)) mi++;
    if (mi == 2048) begin
      mi = 1024;
      ex++;
    end
    return {sgn, 5'(ex + 15), 10'(mi - 1024)};
  endfunction

  function automatic lane_t model_lane(logic [15:0] t);
    lane_t r;
    real v, kr;
    bit hi = 0;
    bit lo = 0;
    r = '0;
    if (t[14:10] == 5'h1f) begin
      if (t[9:0] != 10'd0) begin
        r.k = K_MAX; r.f = 16'h7E00; r.sat = 1'b1; r.nan = 1'b1;
      end else if (t[15]) lo = 1;
      else hi = 1;
    end else begin
      v  = fp16_to_real(t);
      kr = $floor(v);
      if (kr > real'(K_MAX)) hi = 1;
      else if (kr < real'(K_MIN)) lo = 1;
      else begin
        r.k = int'(kr);
        r.f = real_to_fp16(v - kr);
        if (r.f == 16'h3C00) begin
          r.f = 16'h0000;
          r.k = r.k + 1;
          if (r.k > K_MAX) hi = 1;
        end
      end
    end
    if (hi) begin r.k = K_MAX; r.f = 16'h3BFF; r.sat = 1'b1; end
    if (lo) begin r.k = K_MIN; r.f = 16'h0000; r.sat = 1'b1; end
    r.kf = real_to_fp16(real'(r.k));
    return r;
  endfunction

  function automatic exp_t model_beat(logic [16*LANES-1:0] t, bit lat);
    exp_t e;
    lane_t l;
    for (int i = 0; i < LANES; i++) begin
      l = model_lane(t[16*i +: 16]);
      e.k[K_W*i +: K_W] = l.k[K_W-1:0];
      e.kf[16*i +: 16]  = l.kf;
      e.f[16*i +: 16]   = l.f;
      e.sat[i]          = l.sat;
      e.nan[i]          = l.nan;
    end
    e.acc = 0;
    e.lat = lat;
    return e;
  endfunction

  function automatic logic [15:0] rand_half();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return {1'($urandom), 5'($urandom_range(0, 14)), 10'($urandom)};
      default: return {1'($urandom), 5'($urandom_range(0, 19)), 10'($urandom)};
    endcase
  endfunction

  function automatic logic [16*LANES-1:0] rand_beat();
    logic [16*LANES-1:0] t;
    for (int i = 0; i < LANES; i++) t[16*i +: 16] = rand_half();
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [16*LANES-1:0] t, input exp_t e);
    int n = 0;
    valid_i = 1'b1;
    t_i     = t;
    @(negedge clk);
    while (!ready_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready_o=0 for %0d cycles, required an accept", n);
    end else begin
      e.acc = cyc;
      sb.push_back(e);
      $display("issue  cyc=%0d t=%h", cyc, t);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_valid_o"}, 64'(valid_o), 64'd0);
    chk({tag, "_k_o"}, 64'(k_o), 64'd0);
    chk({tag, "_k_fp16_o"}, 64'(k_fp16_o), 64'd0);
    chk({tag, "_f_o"}, 64'(f_o), 64'd0);
`ifdef BASE2_RR_FLAGS_EN
    chk({tag, "_sat_o"}, 64'(sat_o), 64'd0);
    chk({tag, "_nan_o"}, 64'(nan_o), 64'd0);
`endif
  endtask

  // Ready_i driver.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = ($urandom_range(0, 3) != 0);
        default: ready_i = 1'b0;
      endcase
    end
  end

  // Monitor.
  logic                 have_prev = 1'b0;
  logic                 prev_stall = 1'b0;
  logic [K_W*LANES-1:0] prev_k;
  logic [16*LANES-1:0]  prev_kf, prev_f;

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_stall) begin
        chk("stall_valid_o", 64'(valid_o), 64'd1);
        chk("stall_k_o", 64'(k_o), 64'(prev_k));
        chk("stall_k_fp16_o", 64'(k_fp16_o), 64'(prev_kf));
        chk("stall_f_o", 64'(f_o), 64'(prev_f));
      end
      chk("ready_o", 64'(ready_o), 64'(!valid_o || ready_i));
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got valid_o=1 k=%h, required no beat", k_o);
        end else begin
          mon_e = sb.pop_front();
          $display("output cyc=%0d k=%h kf=%h f=%h", cyc, k_o, k_fp16_o, f_o);
          chk("k_o", 64'(k_o), 64'(mon_e.k));
          chk("k_fp16_o", 64'(k_fp16_o), 64'(mon_e.kf));
          chk("f_o", 64'(f_o), 64'(mon_e.f));
`ifdef BASE2_RR_FLAGS_EN
          chk("sat_o", 64'(sat_o), 64'(mon_e.sat));
          chk("nan_o", 64'(nan_o), 64'(mon_e.nan));
`endif
          if (mon_e.lat) chk("latency", 64'(cyc - mon_e.acc), 64'd2);
          else           chk("min_latency", 64'((cyc - mon_e.acc) >= 2), 64'd1);
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_k     = k_o;
      prev_kf    = k_fp16_o;
      prev_f     = f_o;
      have_prev  = 1'b1;
    end
  end

  initial begin
    exp_t e;
    logic [16*LANES-1:0] t;
    rst     = 1'b1;
    valid_i = 1'b0;
    t_i     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived expectations.
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < LANES; i++) begin
        t[16*i +: 16]      = dt[v][i];
        e.k[K_W*i +: K_W]  = K_W'(dk[v][i]);
        e.kf[16*i +: 16]   = dkf[v][i];
        e.f[16*i +: 16]    = df[v][i];
      end
      e.sat = dsat[v];
      e.nan = dnan[v];
      e.acc = 0;
      e.lat = 1'b1;
      send(t, e);
    end
    drain();

    // Back-to-back stream of 8 beats, each exactly 2 cycles.
    for (int b = 0; b < 8; b++) begin
      t = rand_beat();
      send(t, model_beat(t, 1'b1));
    end
    drain();

    // Downstream stall for 5 cycles in the middle of a stream.
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          t = rand_beat();
          send(t, model_beat(t, 1'b0));
        end
      end
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    // Reset with two beats in flight; neither may come out.
    t = rand_beat();
    send(t, model_beat(t, 1'b1));
    t = rand_beat();
    send(t, model_beat(t, 1'b1));
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    chk("midreset_ready_o", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    t = rand_beat();
    send(t, model_beat(t, 1'b1));
    drain();

    // Random traffic with random back-pressure and gaps.
    rdy_mode = 1;
    for (int b = 0; b < 150; b++) begin
      t = rand_beat();
      send(t, model_beat(t, 1'b0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
